// File: rtl/goomba_scheduler.sv
// Goomba spawn scheduler: queues spawn requests, starts at most one goomba per frame in the
// lowest free slot, confirms it came alive, and holds every slot in kill while Mario is dead.
//
// state   | meaning
// IDLE    | waiting for a frame tick with a queued request and a free slot
// ISSUE   | one-cycle start pulse to the chosen slot, FIFO head popped
// CONFIRM | waiting up to 8 cycles for the chosen slot to report alive
// DEAD    | Mario killed; all slots held in kill until restart
module goomba_scheduler (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       spawn_valid,
    output logic       spawn_ready,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    input  logic [3:0] goomba_alive,
    input  logic [3:0] goomba_kill_mario,
    input  logic       restart,
    output logic [3:0] goomba_start,
    output logic [3:0] goomba_kill,
    output logic [9:0] goomba_spawnX,
    output logic [9:0] goomba_spawnY,
    output logic       mario_dead,
    output logic [2:0] active_count,
    output logic       spawn_fail
);

    typedef enum logic [1:0] {IDLE, ISSUE, CONFIRM, DEAD} state_t;

    state_t      state, state_nxt;
    logic        frame_clk_d;
    logic        frame_tick;
    logic [19:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_full, fifo_empty;
    logic        push, pop;
    logic        reserved;
    logic [1:0]  res_slot;
    logic [3:0]  res_mask, free_mask;
    logic [1:0]  sel_slot;
    logic        any_free;
    logic        kill_hit, enter_dead;
    logic        confirmed, timeout;
    logic [2:0]  timer;

    assign frame_tick = frame_clk & ~frame_clk_d;
    assign fifo_full  = (fifo_count == 3'd4);
    assign fifo_empty = (fifo_count == 3'd0);
    assign spawn_ready = !fifo_full && (state != DEAD);
    assign push = spawn_valid && spawn_ready;
    assign pop  = (state == ISSUE);

    assign res_mask  = reserved ? (4'b0001 << res_slot) : 4'b0000;
    assign free_mask = ~goomba_alive & ~res_mask;
    assign any_free  = |free_mask;

    assign kill_hit   = |(goomba_kill_mario & goomba_alive);
    assign enter_dead = kill_hit && (state != DEAD);
    assign confirmed  = goomba_alive[res_slot];
    assign timeout    = (state == CONFIRM) && (timer == 3'd0) && !confirmed;

    always_comb begin
        sel_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (free_mask[i]) sel_slot = 2'(i);
        end
    end

    always_comb begin
        active_count = 3'(goomba_alive[0]) + 3'(goomba_alive[1])
                     + 3'(goomba_alive[2]) + 3'(goomba_alive[3]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Death check sits ahead of every other transition in each live state.
    always_comb begin
        state_nxt    = state;
        goomba_start = 4'b0000;
        goomba_kill  = 4'b0000;
        mario_dead   = 1'b0;
        case (state)
            IDLE: begin
                if (kill_hit)                                    state_nxt = DEAD;
                else if (frame_tick && !fifo_empty && any_free)  state_nxt = ISSUE;
            end
            ISSUE: begin
                goomba_start = 4'b0001 << res_slot;
                state_nxt    = kill_hit ? DEAD : CONFIRM;
            end
            CONFIRM: begin
                if (kill_hit)                            state_nxt = DEAD;
                else if (confirmed || timer == 3'd0)     state_nxt = IDLE;
            end
            DEAD: begin
                goomba_kill = 4'b1111;
                mario_dead  = 1'b1;
                if (restart) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= {spawn_x, spawn_y};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d   <= 1'b0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            fifo_count    <= 3'd0;
            reserved      <= 1'b0;
            res_slot      <= 2'd0;
            timer         <= 3'd0;
            goomba_spawnX <= 10'd0;
            goomba_spawnY <= 10'd0;
            spawn_fail    <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            spawn_fail  <= timeout && !kill_hit;
            if (enter_dead) begin
                wr_ptr     <= 2'd0;
                rd_ptr     <= 2'd0;
                fifo_count <= 3'd0;
                reserved   <= 1'b0;
                timer      <= 3'd0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 2'd1;
                if (pop)  rd_ptr <= rd_ptr + 2'd1;
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 3'd1;
                    2'b01:   fifo_count <= fifo_count - 3'd1;
                    default: fifo_count <= fifo_count;
                endcase
                if (state == IDLE && state_nxt == ISSUE) begin
                    res_slot      <= sel_slot;
                    reserved      <= 1'b1;
                    goomba_spawnX <= fifo_mem[rd_ptr][19:10];
                    goomba_spawnY <= fifo_mem[rd_ptr][9:0];
                end
                // Timer counts down the 8 confirm cycles; terminal count is 0.
                if (state == ISSUE) timer <= 3'd7;
                if (state == CONFIRM) begin
                    if (state_nxt == IDLE) reserved <= 1'b0;
                    else                   timer    <= timer - 3'd1;
                end
            end
        end
    end

endmodule
